// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt responder and the CSR/trap logic.
// Holds the FSM state encoding, source-select encoding, default mcause codes,
// mip bit positions and a helper that builds an interrupt mcause value.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef enum logic {
        SEL_TMR = 1'b0,
        SEL_EXT = 1'b1
    } sel_t;

    localparam int MTI_CODE_DEF = 7;
    localparam int MEI_CODE_DEF = 11;

    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

    // Interrupt mcause: interrupt flag in bit 31, exception code in [3:0].
    function automatic logic [31:0] make_cause(input logic [3:0] code);
        return {1'b1, 27'b0, code};
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/int_ctrl.sv
// int_ctrl: CPU-side responder for the timer and external interrupt lines.
// Qualifies the level requests with the CSR enables, picks one (external wins
// over timer), presents it to the trap logic, pulses the matching ack once the
// pipeline commits trap entry, then waits for the source to drop its line.
//
// Ports:
//   clk, reset      core clock, asynchronous active-high reset
//   timer_int       level request from timer, held until acked
//   external_int    level request from external generator, held until acked
//   global_ie       mstatus.MIE
//   mtie, meie      mie.MTIE, mie.MEIE
//   irq_take        1-cycle pulse: pipeline committed trap entry for irq_req
//   irq_req         interrupt request to trap logic
//   irq_cause       mcause value while irq_req=1, else 0
//   timer_int_ack   ack pulse to the timer
//   ext_int_ack     ack pulse to the external generator
//   mip             registered pending bits (7=timer, 11=external)
//   int_err         sticky: acked source failed to deassert in time
//   dbg_state       current FSM state
//
// Handshake: irq_req is a level "valid" that stays high with a constant
// irq_cause until either irq_take (the "ready" pulse) arrives in a cycle where
// irq_req=1, or the selected source stops being eligible, in which case the
// request is withdrawn. irq_take while irq_req=0 has no effect. A take in the
// same cycle as an enable drop is honoured.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int ACK_PULSE_LEN    = 1,
    parameter int DEASSERT_TIMEOUT = 16,
    parameter int MTI_CODE         = MTI_CODE_DEF,
    parameter int MEI_CODE         = MEI_CODE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_int,
    input  logic        external_int,
    input  logic        global_ie,
    input  logic        mtie,
    input  logic        meie,
    input  logic        irq_take,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic        timer_int_ack,
    output logic        ext_int_ack,
    output logic [31:0] mip,
    output logic        int_err,
    output state_t      dbg_state
);

    localparam int CNT_MAX = max2(ACK_PULSE_LEN, DEASSERT_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_PULSE_LEN);
    // Compared against the count of DRAIN cycles already spent with the pin high.
    localparam logic [CW-1:0] TO_LAST  = CW'(DEASSERT_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT  = '1;

    localparam logic [3:0] MTI_C = 4'(MTI_CODE);
    localparam logic [3:0] MEI_C = 4'(MEI_CODE);

    state_t        state;
    sel_t          sel;
    logic [CW-1:0] cnt;

    logic          eligible_e;
    logic          eligible_t;
    logic          sel_eligible;
    logic          sel_pin;
    logic [31:0]   mip_next;
    logic [CW-1:0] cnt_inc;

    assign eligible_e   = external_int & meie & global_ie;
    assign eligible_t   = timer_int & mtie & global_ie;
    assign sel_eligible = (sel == SEL_EXT) ? eligible_e : eligible_t;
    assign sel_pin      = (sel == SEL_EXT) ? external_int : timer_int;
    // Saturating increment so a long DRAIN can never wrap back to a small count.
    assign cnt_inc      = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    assign dbg_state    = state;

    always_comb begin
        mip_next               = '0;
        mip_next[MIP_MTIP_BIT] = timer_int;
        mip_next[MIP_MEIP_BIT] = external_int;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            sel           <= SEL_TMR;
            cnt           <= '0;
            irq_req       <= 1'b0;
            irq_cause     <= '0;
            timer_int_ack <= 1'b0;
            ext_int_ack   <= 1'b0;
            mip           <= '0;
            int_err       <= 1'b0;
        end else begin
            mip <= mip_next;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (eligible_e) begin
                        sel       <= SEL_EXT;
                        irq_req   <= 1'b1;
                        irq_cause <= make_cause(MEI_C);
                        state     <= ST_REQ;
                    end else if (eligible_t) begin
                        sel       <= SEL_TMR;
                        irq_req   <= 1'b1;
                        irq_cause <= make_cause(MTI_C);
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Selection is frozen here: a late external does not pre-empt.
                    if (irq_take) begin
                        irq_req   <= 1'b0;
                        irq_cause <= '0;
                        cnt       <= {{(CW-1){1'b0}}, 1'b1};
                        state     <= ST_ACK;
                        if (sel == SEL_EXT) ext_int_ack   <= 1'b1;
                        else                timer_int_ack <= 1'b1;
                    end else if (!sel_eligible) begin
                        irq_req   <= 1'b0;
                        irq_cause <= '0;
                        state     <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    // cnt counts ack cycles already presented, starting at 1.
                    if (cnt >= ACK_LAST) begin
                        timer_int_ack <= 1'b0;
                        ext_int_ack   <= 1'b0;
                        cnt           <= '0;
                        state         <= ST_DRAIN;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DRAIN: begin
                    if (!sel_pin) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt >= TO_LAST) begin
                        int_err <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
